// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard/stall control block.
// Holds the FSM state encoding, the x0 register id and the ID/EX NOP control word.
package hazard_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'b00,
    LSTALL = 2'b01,
    MWAIT  = 2'b10
  } hz_state_e;

  localparam logic [4:0] REG_X0 = 5'd0;

  // Control word the ID/EX stage loads when idex_bubble is asserted.
  typedef struct packed {
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       branch;
    logic       jump;
    logic [3:0] alu_op;
  } idex_ctrl_t;

  localparam idex_ctrl_t NOP_CTRL = '0;

endpackage

// File: rtl/hazard_perf_counter.sv
// Saturating event counter: counts cycles with inc=1, sticks at all-ones.
// Single-cycle update, no backpressure; cleared by asynchronous active-low reset.
module hazard_perf_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/hazard_stall_unit.sv
// Load-use stall, taken-branch flush and data-memory wait control for a 5-stage pipe.
// Mealy outputs (same-cycle); HAZARD_PERF_CNT_EN adds stall/flush performance counters.
module hazard_stall_unit
  import hazard_pkg::*;
#(
  parameter int LOAD_STALL_CYCLES = 1,
  parameter int CNT_W             = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [4:0]       ifid_rs1,
  input  logic [4:0]       ifid_rs2,
  input  logic             ifid_uses_rs2,
  input  logic [4:0]       idex_rd,
  input  logic             idex_memRead,
  input  logic             branch_taken,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             pipe_hold,
  output logic [1:0]       state_o
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
`endif
);

  if (LOAD_STALL_CYCLES < 1 || LOAD_STALL_CYCLES > 7 || CNT_W < 1) begin : g_bad_param
    $error("hazard_stall_unit: LOAD_STALL_CYCLES must be 1..7 and CNT_W >= 1");
  end

  localparam logic [2:0] STALL_RELOAD = 3'(LOAD_STALL_CYCLES - 1);
  localparam bit         MULTI_STALL  = (LOAD_STALL_CYCLES > 1);

  hz_state_e  state, state_nxt, eff_state;
  logic [2:0] stall_cnt, stall_cnt_nxt;

  logic load_use;
  logic mem_wait;
  logic pc_w, ifid_w, flush_w, bubble_w, hold_w;

  assign load_use = idex_memRead && (idex_rd != REG_X0) &&
                    ((idex_rd == ifid_rs1) || (ifid_uses_rs2 && (idex_rd == ifid_rs2)));
  assign mem_wait = dmem_req && !dmem_ready;

  // A finished memory wait behaves as whichever state it interrupted.
  always_comb begin
    case (state)
      LSTALL:  eff_state = LSTALL;
      MWAIT:   eff_state = (stall_cnt == 3'd0) ? RUN : LSTALL;
      default: eff_state = RUN;
    endcase
  end

  always_comb begin
    pc_w          = 1'b1;
    ifid_w        = 1'b1;
    flush_w       = 1'b0;
    bubble_w      = 1'b0;
    hold_w        = 1'b0;
    state_nxt     = RUN;
    stall_cnt_nxt = stall_cnt;

    if (mem_wait) begin
      pc_w      = 1'b0;
      ifid_w    = 1'b0;
      hold_w    = 1'b1;
      state_nxt = MWAIT;
    end else if (branch_taken) begin
      // The squashed consumer no longer needs any pending load-use bubbles.
      flush_w       = 1'b1;
      bubble_w      = 1'b1;
      stall_cnt_nxt = 3'd0;
    end else if (eff_state == LSTALL) begin
      pc_w     = 1'b0;
      ifid_w   = 1'b0;
      bubble_w = 1'b1;
      if (stall_cnt > 3'd1) begin
        state_nxt     = LSTALL;
        stall_cnt_nxt = stall_cnt - 3'd1;
      end else begin
        stall_cnt_nxt = 3'd0;
      end
    end else if (load_use) begin
      pc_w     = 1'b0;
      ifid_w   = 1'b0;
      bubble_w = 1'b1;
      if (MULTI_STALL) begin
        state_nxt     = LSTALL;
        stall_cnt_nxt = STALL_RELOAD;
      end else begin
        stall_cnt_nxt = 3'd0;
      end
    end else begin
      stall_cnt_nxt = 3'd0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= RUN;
      stall_cnt <= 3'd0;
    end else begin
      state     <= state_nxt;
      stall_cnt <= stall_cnt_nxt;
    end
  end

  // Hold every enable low while reset is asserted so nothing advances.
  assign pc_write    = reset_n & pc_w;
  assign ifid_write  = reset_n & ifid_w;
  assign ifid_flush  = reset_n & flush_w;
  assign idex_bubble = reset_n & bubble_w;
  assign pipe_hold   = reset_n & hold_w;
  assign state_o     = state;

`ifdef HAZARD_PERF_CNT_EN
  hazard_perf_counter #(.W(CNT_W)) u_stall_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     (!pc_write),
    .count   (stall_cycles)
  );

  hazard_perf_counter #(.W(CNT_W)) u_flush_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     (ifid_flush),
    .count   (flush_count)
  );
`endif

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Scoreboard bench for hazard_stall_unit: two instances (LOAD_STALL_CYCLES=1 and 3).
// Stimulus pushes expected outputs; a negedge monitor pops and compares them.
module tb_hazard_stall_unit;

  typedef struct packed {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       u2;
    logic [4:0] rd;
    logic       mr;
    logic       br;
    logic       req;
    logic       rdy;
  } stim_t;

  typedef struct {
    int         sel;
    logic [6:0] exp;
    string      name;
  } exp_t;

  // {pc_write, ifid_write, ifid_flush, idex_bubble, pipe_hold, state_o}
  localparam logic [6:0] ZERO   = 7'b0000000;
  localparam logic [6:0] DEF0   = 7'b1100000;
  localparam logic [6:0] STALL0 = 7'b0001000;
  localparam logic [6:0] STALL1 = 7'b0001001;
  localparam logic [6:0] STALL2 = 7'b0001010;
  localparam logic [6:0] HOLD0  = 7'b0000100;
  localparam logic [6:0] HOLD1  = 7'b0000101;
  localparam logic [6:0] HOLD2  = 7'b0000110;
  localparam logic [6:0] FLUSH0 = 7'b1111000;
  localparam logic [6:0] FLUSH1 = 7'b1111001;
  localparam logic [6:0] FLUSH2 = 7'b1111010;

  logic  clk = 1'b0;
  logic  reset_n;
  stim_t s1, s3;
  exp_t  q[$];
  int    n_vec = 0;
  int    n_bad = 0;

  logic       pc1, ifw1, fl1, bub1, hold1;
  logic [1:0] st1;
  logic       pc3, ifw3, fl3, bub3, hold3;
  logic [1:0] st3;
`ifdef HAZARD_PERF_CNT_EN
  logic [3:0] sc1, fc1, sc3, fc3;
`endif

  always #5 clk = ~clk;

  hazard_stall_unit #(.LOAD_STALL_CYCLES(1), .CNT_W(4)) dut1 (
    .clk(clk), .reset_n(reset_n),
    .ifid_rs1(s1.rs1), .ifid_rs2(s1.rs2), .ifid_uses_rs2(s1.u2),
    .idex_rd(s1.rd), .idex_memRead(s1.mr), .branch_taken(s1.br),
    .dmem_req(s1.req), .dmem_ready(s1.rdy),
    .pc_write(pc1), .ifid_write(ifw1), .ifid_flush(fl1),
    .idex_bubble(bub1), .pipe_hold(hold1), .state_o(st1)
`ifdef HAZARD_PERF_CNT_EN
    , .stall_cycles(sc1), .flush_count(fc1)
`endif
  );

  hazard_stall_unit #(.LOAD_STALL_CYCLES(3), .CNT_W(4)) dut3 (
    .clk(clk), .reset_n(reset_n),
    .ifid_rs1(s3.rs1), .ifid_rs2(s3.rs2), .ifid_uses_rs2(s3.u2),
    .idex_rd(s3.rd), .idex_memRead(s3.mr), .branch_taken(s3.br),
    .dmem_req(s3.req), .dmem_ready(s3.rdy),
    .pc_write(pc3), .ifid_write(ifw3), .ifid_flush(fl3),
    .idex_bubble(bub3), .pipe_hold(hold3), .state_o(st3)
`ifdef HAZARD_PERF_CNT_EN
    , .stall_cycles(sc3), .flush_count(fc3)
`endif
  );

  wire [6:0] act1 = {pc1, ifw1, fl1, bub1, hold1, st1};
  wire [6:0] act3 = {pc3, ifw3, fl3, bub3, hold3, st3};

  // Monitor: outputs are combinational, so they are settled by the falling edge.
  exp_t       mon_e;
  logic [6:0] mon_act;
  always @(negedge clk) begin
    while (q.size() > 0) begin
      mon_e   = q.pop_front();
      mon_act = (mon_e.sel == 3) ? act3 : act1;
      n_vec++;
      if (mon_act !== mon_e.exp) begin
        n_bad++;
        $display("FAIL %s (dut%0d): got %b expected %b", mon_e.name, mon_e.sel, mon_act, mon_e.exp);
      end
    end
  end

  function automatic stim_t mk(input logic [4:0] rs1, input logic [4:0] rs2, input logic u2,
                               input logic [4:0] rd, input logic mr, input logic br,
                               input logic req, input logic rdy);
    stim_t s;
    s = '{rs1: rs1, rs2: rs2, u2: u2, rd: rd, mr: mr, br: br, req: req, rdy: rdy};
    return s;
  endfunction

  task automatic chk(input int sel, input logic [6:0] exp, input string name);
    exp_t e;
    e.sel  = sel;
    e.exp  = exp;
    e.name = name;
    q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one DUT for a cycle (the other idles) and queue its expected outputs.
  task automatic vec(input int sel, input stim_t s, input logic [6:0] exp, input string name);
    if (sel == 3) begin s3 = s; s1 = '0; end
    else          begin s1 = s; s3 = '0; end
    chk(sel, exp, name);
    tick();
  endtask

  task automatic reset_cycle(input string name);
    reset_n = 1'b0;
    s1 = '0;
    s3 = '0;
    chk(1, ZERO, name);
    chk(3, ZERO, name);
    tick();
    reset_n = 1'b1;
    chk(1, DEF0, {name, "_release"});
    chk(3, DEF0, {name, "_release"});
    tick();
  endtask

  stim_t idle, lu5, lu0, rs2_off, rs2_on, wait_br, rdy_br, br_only, wait_only, rdy_only, lu5_wait, lu5_rdy;

  initial begin
    idle      = '0;
    lu5       = mk(5'd5, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
    lu0       = mk(5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    rs2_off   = mk(5'd3, 5'd7, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0);
    rs2_on    = mk(5'd3, 5'd7, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0);
    wait_br   = mk(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0);
    rdy_br    = mk(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1);
    br_only   = mk(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    wait_only = mk(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    rdy_only  = mk(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    lu5_wait  = mk(5'd5, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b0);
    lu5_rdy   = mk(5'd5, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b1);

    reset_n = 1'b0;
    s1 = '0;
    s3 = '0;
    tick();
    reset_cycle("por");

    // Single-bubble load-use, x0 load, rs2 gating
    vec(1, lu5,     STALL0, "lu_rs1");
    vec(1, idle,    DEF0,   "lu_after");
    vec(1, lu0,     DEF0,   "lu_x0");
    vec(1, rs2_off, DEF0,   "rs2_unused");
    vec(1, rs2_on,  STALL0, "rs2_used");
    vec(1, idle,    DEF0,   "rs2_after");

    // Memory wait masks a taken branch until the access completes
    vec(1, wait_br, HOLD0,  "mwait_c1");
    vec(1, wait_br, HOLD2,  "mwait_c2");
    vec(1, wait_br, HOLD2,  "mwait_c3");
    vec(1, wait_br, HOLD2,  "mwait_c4");
    vec(1, rdy_br,  FLUSH2, "mwait_done_flush");
    vec(1, idle,    DEF0,   "mwait_after");

    // Load-use arriving together with a memory wait
    vec(1, lu5_wait, HOLD0,  "lu_wait_hold");
    vec(1, lu5_rdy,  STALL2, "lu_wait_release");
    vec(1, idle,     DEF0,   "lu_wait_after");

    // Three-bubble stall: state 00 -> 01 -> 01 -> 00
    vec(3, lu5,  STALL0, "ms_b1");
    vec(3, idle, STALL1, "ms_b2");
    vec(3, idle, STALL1, "ms_b3");
    vec(3, idle, DEF0,   "ms_done");

    // Branch in the second bubble cancels the third
    vec(3, lu5,     STALL0, "msbr_b1");
    vec(3, br_only, FLUSH1, "msbr_flush");
    vec(3, idle,    DEF0,   "msbr_no_b3");

    // Memory wait in the middle of a stall resumes the countdown
    vec(3, lu5,       STALL0, "mslw_b1");
    vec(3, wait_only, HOLD1,  "mslw_hold");
    vec(3, rdy_only,  STALL2, "mslw_b2");
    vec(3, idle,      STALL1, "mslw_b3");
    vec(3, idle,      DEF0,   "mslw_done");

    // Asynchronous reset in the middle of LSTALL
    vec(3, lu5, STALL0, "rst_b1");
    reset_cycle("rst_mid_lstall");
    vec(3, idle, DEF0, "rst_no_residual");

`ifdef HAZARD_PERF_CNT_EN
    reset_cycle("perf_clear");
    vec(1, wait_only, HOLD0, "perf_hold_first");
    for (int i = 0; i < 19; i++) vec(1, wait_only, HOLD2, "perf_hold");
    vec(1, br_only, FLUSH2, "perf_flush1");
    vec(1, br_only, FLUSH0, "perf_flush2");
    vec(1, idle,    DEF0,   "perf_idle");
    n_vec++;
    if (sc1 !== 4'hF) begin
      n_bad++;
      $display("FAIL perf_stall_sat: got %h expected f", sc1);
    end
    n_vec++;
    if (fc1 !== 4'd2) begin
      n_bad++;
      $display("FAIL perf_flush_count: got %0d expected 2", fc1);
    end
`endif

    for (int i = 0; i < 10; i++) begin
      if (q.size() == 0) break;
      tick();
    end
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
